// File: rtl/avalon_burst_reader_pkg.sv
//------------------------------------------------------------------------------
// Module : avalon_burst_reader_pkg
// Brief  : Shared types and helpers for the Avalon-MM burst read initiator.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package avalon_burst_reader_pkg;

   // Read initiator control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_e;

   // Largest burst expressible by a burstcount field of the given width
   function automatic int unsigned burst_max(input int unsigned bsize_w);
      return 32'd1 << (bsize_w - 32'd1);
   endfunction

   // Byte-enable width for a data word of the given width
   function automatic int unsigned be_width(input int unsigned data_w);
      return data_w / 32'd8;
   endfunction

endpackage

`default_nettype wire

// File: rtl/avalon_burst_reader_fifo.sv
//------------------------------------------------------------------------------
// Module : avalon_burst_reader_fifo
// Brief  : Synchronous show-ahead FIFO with occupancy count; buffers read beats.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module avalon_burst_reader_fifo #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DEPTH      = 32
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          push_i,
   input  logic [DATA_WIDTH-1:0]         wdata_i,
   input  logic                          pop_i,
   output logic [DATA_WIDTH-1:0]         rdata_o,
   output logic                          empty_o,
   output logic [$clog2(DEPTH):0]        count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q;
   logic [AW-1:0]         rd_ptr_q;
   logic [CW-1:0]         count_q;
   logic                  full;
   logic                  do_push;
   logic                  do_pop;

   assign empty_o = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   // A pop frees the slot, so a push into a full FIFO is fine in the same cycle
   assign do_push = push_i && (!full || do_pop);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Storage write; contents need no reset because count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // The upstream credit scheme must never push into a full FIFO
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(push_i && full && !do_pop));

endmodule

`default_nettype wire

// File: rtl/avalon_burst_reader.sv
//------------------------------------------------------------------------------
// Module : avalon_burst_reader
// Brief  : Avalon-MM read initiator; splits {addr,len} commands into bursts,
//          buffers returned beats and streams them out with a last flag.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module avalon_burst_reader
   import avalon_burst_reader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned MAX_BSIZE  = 4,
   parameter int unsigned LEN_WIDTH  = 24,
   parameter int unsigned FIFO_DEPTH = 32
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [ADDR_WIDTH-1:0]         cmd_addr,
   input  logic [LEN_WIDTH-1:0]          cmd_len,
   input  logic                          avl_ready,
   output logic [ADDR_WIDTH-1:0]         avl_addr,
   output logic                          avl_read_req,
   output logic                          avl_write_req,
   output logic [DATA_WIDTH-1:0]         avl_wdata,
   output logic [DATA_WIDTH/8-1:0]       avl_be,
   output logic [MAX_BSIZE-1:0]          avl_size,
   input  logic                          avl_rdata_valid,
   input  logic [DATA_WIDTH-1:0]         avl_rdata,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_last,
   input  logic                          out_ready,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned BE_WIDTH  = be_width(DATA_WIDTH);
   localparam int unsigned MAX_BURST = burst_max(MAX_BSIZE);
   localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

   rd_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  req_rem_q, req_rem_d;
   logic [LEN_WIDTH-1:0]  deliv_q, deliv_d;
   logic [CNT_WIDTH-1:0]  outst_q, outst_d;
   logic                  done_q, done_d;

   logic [CNT_WIDTH-1:0]  fifo_count;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic [MAX_BSIZE-1:0]  bsz;
   logic [CNT_WIDTH-1:0]  credit;
   logic                  issue;
   logic                  beat_accept;
   logic                  pop;
   logic                  last_word;

   // Next burst never exceeds MAX_BURST and never overruns the command
   assign bsz = (req_rem_q < LEN_WIDTH'(MAX_BURST)) ? req_rem_q[MAX_BSIZE-1:0]
                                                    : MAX_BSIZE'(MAX_BURST);
   // Space left once every beat already requested has landed in the FIFO
   assign credit      = CNT_WIDTH'(FIFO_DEPTH) - fifo_count - outst_q;
   assign issue       = avl_read_req && avl_ready;
   // Beats arriving with nothing outstanding are stray and are discarded
   assign beat_accept = avl_rdata_valid && (outst_q != '0);
   assign pop         = out_valid && out_ready;
   assign last_word   = out_valid && (deliv_q == len_q - LEN_WIDTH'(1));

   assign cmd_ready     = (state_q == ST_IDLE);
   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;
   assign avl_read_req  = (state_q == ST_ISSUE) && (credit >= CNT_WIDTH'(bsz));
   assign avl_addr      = addr_q;
   assign avl_size      = (state_q == ST_ISSUE) ? bsz : '0;
   assign avl_write_req = 1'b0;
   assign avl_wdata     = '0;
   assign avl_be        = '1;
   assign out_valid     = !fifo_empty;
   assign out_data      = fifo_rdata;
   assign out_last      = last_word;

   avalon_burst_reader_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (beat_accept),
      .wdata_i (avl_rdata),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Command sequencing, burst address stepping and beat accounting
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      req_rem_d = req_rem_q;
      deliv_d   = deliv_q;
      done_d    = 1'b0;
      outst_d   = outst_q + (issue ? CNT_WIDTH'(bsz) : '0)
                          - (beat_accept ? CNT_WIDTH'(1) : '0);
      if (pop) begin
         deliv_d = deliv_q + LEN_WIDTH'(1);
      end
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               addr_d    = cmd_addr;
               len_d     = cmd_len;
               req_rem_d = cmd_len;
               deliv_d   = '0;
               if (cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (issue) begin
               addr_d    = addr_q + ADDR_WIDTH'(bsz) * ADDR_WIDTH'(BE_WIDTH);
               req_rem_d = req_rem_q - LEN_WIDTH'(bsz);
               if (req_rem_q == LEN_WIDTH'(bsz)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (pop && last_word && (outst_q == '0)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and counter registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         req_rem_q <= '0;
         deliv_q   <= '0;
         outst_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         req_rem_q <= req_rem_d;
         deliv_q   <= deliv_d;
         outst_q   <= outst_d;
         done_q    <= done_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_avalon_burst_reader.sv
//------------------------------------------------------------------------------
// Module : tb_avalon_burst_reader
// Brief  : Self-checking bench for avalon_burst_reader with a bridge model and
//          a command-level reference model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_avalon_burst_reader;

   localparam int unsigned DEPTH = 16;

   typedef struct {
      logic [63:0] addr;
      int unsigned size;
   } burst_t;

   logic        clk;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [63:0] cmd_addr;
   logic [23:0] cmd_len;
   logic        avl_ready;
   logic [63:0] avl_addr;
   logic        avl_read_req;
   logic        avl_write_req;
   logic [63:0] avl_wdata;
   logic [7:0]  avl_be;
   logic [3:0]  avl_size;
   logic        avl_rdata_valid;
   logic [63:0] avl_rdata;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_last;
   logic        out_ready;
   logic        busy;
   logic        done;

   avalon_burst_reader #(
      .ADDR_WIDTH (64),
      .DATA_WIDTH (64),
      .MAX_BSIZE  (4),
      .LEN_WIDTH  (24),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_addr        (cmd_addr),
      .cmd_len         (cmd_len),
      .avl_ready       (avl_ready),
      .avl_addr        (avl_addr),
      .avl_read_req    (avl_read_req),
      .avl_write_req   (avl_write_req),
      .avl_wdata       (avl_wdata),
      .avl_be          (avl_be),
      .avl_size        (avl_size),
      .avl_rdata_valid (avl_rdata_valid),
      .avl_rdata       (avl_rdata),
      .out_valid       (out_valid),
      .out_data        (out_data),
      .out_last        (out_last),
      .out_ready       (out_ready),
      .busy            (busy),
      .done            (done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [63:0] exp_words[$];
   burst_t      exp_bursts[$];
   logic [63:0] beat_q[$];
   burst_t      burst_log[$];
   int          inflight     = 0;
   int          max_inflight = 0;
   bit          exp_done     = 0;
   bit          exp_busy     = 0;
   bit          prev_stall   = 0;
   logic [63:0] prev_addr    = '0;
   logic [3:0]  prev_size    = '0;
   int          stall_cnt    = 0;
   int          words_seen   = 0;
   int          done_cnt     = 0;

   // Bridge / sink behaviour knobs
   int ar_mode      = 0;
   int orm          = 0;
   int ready_low    = 0;
   int hold_out_cnt = 0;
   bit spurious     = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   function automatic logic [63:0] mem_word(input logic [63:0] a);
      return {a[31:0] ^ 32'hC3A5_5A3C, a[63:32] ^ (a[31:0] * 32'd2654435761)};
   endfunction

   task automatic chk(input bit ok, input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Bridge slave and stream sink: inputs change 1 time unit after each edge
   initial begin
      avl_ready       = 1'b0;
      avl_rdata_valid = 1'b0;
      avl_rdata       = '0;
      out_ready       = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (ready_low > 0) begin
            avl_ready = 1'b0;
            ready_low--;
         end else begin
            avl_ready = (ar_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         end
         if (hold_out_cnt > 0) begin
            out_ready = 1'b0;
            hold_out_cnt--;
         end else begin
            out_ready = (orm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         end
         if (spurious) begin
            avl_rdata_valid = 1'b1;
            avl_rdata       = 64'hDEAD_0000_BEEF_0000;
            spurious        = 0;
         end else if (beat_q.size() > 0 && (ar_mode == 0 || $urandom_range(0, 2) != 0)) begin
            avl_rdata_valid = 1'b1;
            avl_rdata       = mem_word(beat_q.pop_front());
         end else begin
            avl_rdata_valid = 1'b0;
            avl_rdata       = {$urandom(), $urandom()};
         end
      end
   end

   // Compare process: everything observed here takes effect at the next edge
   always @(negedge clk) begin
      burst_t      b;
      logic [63:0] w;
      bit          last_exp;
      bit          req_exp;
      if (!reset_n) begin
         exp_words.delete();
         exp_bursts.delete();
         beat_q.delete();
         inflight   = 0;
         exp_done   = 0;
         exp_busy   = 0;
         prev_stall = 0;
      end else begin
         chk(done === exp_done, "done", 64'(done), 64'(exp_done));
         chk(busy === exp_busy, "busy", 64'(busy), 64'(exp_busy));
         exp_done = 0;
         req_exp = (exp_bursts.size() > 0) ? (inflight + int'(exp_bursts[0].size) <= DEPTH) : 1'b0;
         chk(avl_read_req === req_exp, "read_req", 64'(avl_read_req), 64'(req_exp));
         if (prev_stall) begin
            stall_cnt++;
            chk(avl_addr === prev_addr, "hold_addr", avl_addr, prev_addr);
            chk(avl_size === prev_size, "hold_size", 64'(avl_size), 64'(prev_size));
         end
         if (avl_read_req && avl_ready && exp_bursts.size() > 0) begin
            b = exp_bursts.pop_front();
            chk(avl_addr === b.addr, "burst_addr", avl_addr, b.addr);
            chk(avl_size === 4'(b.size), "burst_size", 64'(avl_size), 64'(b.size));
            for (int j = 0; j < int'(b.size); j++) begin
               beat_q.push_back(b.addr + 64'(8 * j));
            end
            inflight += int'(b.size);
            if (inflight > max_inflight) max_inflight = inflight;
            b.addr = avl_addr;
            b.size = 32'(avl_size);
            burst_log.push_back(b);
         end
         prev_stall = avl_read_req && !avl_ready;
         prev_addr  = avl_addr;
         prev_size  = avl_size;
         if (out_valid && out_ready) begin
            chk(exp_words.size() != 0, "extra_word", out_data, 64'h0);
            if (exp_words.size() != 0) begin
               w        = exp_words.pop_front();
               last_exp = (exp_words.size() == 0);
               chk(out_data === w, "data", out_data, w);
               chk(out_last === last_exp, "last", 64'(out_last), 64'(last_exp));
               words_seen++;
               inflight--;
               if (last_exp) begin
                  exp_done = 1;
                  exp_busy = 0;
               end
            end
         end
         if (done) done_cnt++;
         if (cmd_valid && cmd_ready) begin
            if (cmd_len == '0) begin
               exp_done = 1;
            end else begin
               logic [63:0] a;
               int          rem;
               exp_busy = 1;
               for (int i = 0; i < int'(cmd_len); i++) begin
                  exp_words.push_back(mem_word(cmd_addr + 64'(8 * i)));
               end
               a   = cmd_addr;
               rem = int'(cmd_len);
               while (rem > 0) begin
                  b.addr = a;
                  b.size = (rem < 8) ? 32'(rem) : 32'd8;
                  exp_bursts.push_back(b);
                  a   = a + 64'(8 * b.size);
                  rem = rem - int'(b.size);
               end
            end
         end
      end
   end

   task automatic clear_log();
      burst_log.delete();
      words_seen   = 0;
      done_cnt     = 0;
      stall_cnt    = 0;
      max_inflight = 0;
   endtask

   task automatic check_reset_values(input string tag);
      chk(cmd_ready === 1'b1,      {tag, "_cmd_ready"}, 64'(cmd_ready), 64'h1);
      chk(avl_read_req === 1'b0,   {tag, "_read_req"},  64'(avl_read_req), 64'h0);
      chk(avl_addr === 64'h0,      {tag, "_avl_addr"},  avl_addr, 64'h0);
      chk(avl_size === 4'h0,       {tag, "_avl_size"},  64'(avl_size), 64'h0);
      chk(out_valid === 1'b0,      {tag, "_out_valid"}, 64'(out_valid), 64'h0);
      chk(out_last === 1'b0,       {tag, "_out_last"},  64'(out_last), 64'h0);
      chk(busy === 1'b0,           {tag, "_busy"},      64'(busy), 64'h0);
      chk(done === 1'b0,           {tag, "_done"},      64'(done), 64'h0);
      chk(avl_write_req === 1'b0,  {tag, "_write_req"}, 64'(avl_write_req), 64'h0);
      chk(avl_wdata === 64'h0,     {tag, "_wdata"},     avl_wdata, 64'h0);
      chk(avl_be === 8'hFF,        {tag, "_be"},        64'(avl_be), 64'hFF);
   endtask

   task automatic run_cmd(input logic [63:0] a, input int unsigned n, input bit wait_done);
      int cyc;
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = 24'(n);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!cmd_ready && cyc < 200);
      chk(cmd_ready === 1'b1, "cmd_accept", 64'(cmd_ready), 64'h1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_addr  = {$urandom(), $urandom()};
      cmd_len   = 24'($urandom());
      @(negedge clk);
      if (n == 0) begin
         chk(done === 1'b1, "len0_done_latency", 64'(done), 64'h1);
      end else begin
         chk(avl_read_req === 1'b1, "first_req_latency", 64'(avl_read_req), 64'h1);
      end
      if (wait_done && n != 0) begin
         cyc = 0;
         while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
         end
         chk(done === 1'b1, "done_timeout", 64'(done), 64'h1);
      end
      if (wait_done) repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [63:0] ra;
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check_reset_values("por");

      // Single full burst
      ar_mode = 0; orm = 0; clear_log();
      run_cmd(64'h1000, 8, 1);
      chk(burst_log.size() == 1, "t1_nbursts", 64'(burst_log.size()), 64'd1);
      chk(burst_log[0].addr == 64'h1000, "t1_addr", burst_log[0].addr, 64'h1000);
      chk(burst_log[0].size == 8, "t1_size", 64'(burst_log[0].size), 64'd8);
      chk(words_seen == 8, "t1_words", 64'(words_seen), 64'd8);
      chk(done_cnt == 1, "t1_done_pulses", 64'(done_cnt), 64'd1);

      // Full burst plus partial tail, with random bus and sink timing
      ar_mode = 1; orm = 1; clear_log();
      run_cmd(64'h1000, 13, 1);
      chk(burst_log.size() == 2, "t2_nbursts", 64'(burst_log.size()), 64'd2);
      chk(burst_log[1].addr == 64'h1040, "t2_addr1", burst_log[1].addr, 64'h1040);
      chk(burst_log[1].size == 5, "t2_size1", 64'(burst_log[1].size), 64'd5);
      chk(words_seen == 13, "t2_words", 64'(words_seen), 64'd13);

      // Bridge stalls the request
      ar_mode = 0; orm = 1; clear_log();
      ready_low = 5;
      run_cmd(64'h2000, 8, 1);
      chk(stall_cnt >= 3, "t3_stalled", 64'(stall_cnt), 64'd3);
      chk(burst_log.size() == 1, "t3_no_dup", 64'(burst_log.size()), 64'd1);

      // Sink back-pressure fills exactly the FIFO depth
      ar_mode = 1; orm = 1; clear_log();
      hold_out_cnt = 100;
      run_cmd(64'h8000, 64, 1);
      chk(max_inflight == DEPTH, "t4_max_buffered", 64'(max_inflight), 64'(DEPTH));
      chk(burst_log.size() == 8, "t4_nbursts", 64'(burst_log.size()), 64'd8);
      chk(words_seen == 64, "t4_words", 64'(words_seen), 64'd64);

      // Zero-length command
      ar_mode = 0; orm = 0; clear_log();
      run_cmd(64'h3000, 0, 1);
      chk(burst_log.size() == 0, "t5_no_bursts", 64'(burst_log.size()), 64'd0);
      chk(done_cnt == 1, "t5_done_pulses", 64'(done_cnt), 64'd1);

      // Address wrap at the top of the space
      clear_log();
      run_cmd(64'hFFFF_FFFF_FFFF_FFC0, 12, 1);
      chk(burst_log[1].addr == 64'h0, "t6_wrap_addr", burst_log[1].addr, 64'h0);
      chk(burst_log[1].size == 4, "t6_wrap_size", 64'(burst_log[1].size), 64'd4);

      // Stray beat while idle is dropped
      spurious = 1;
      repeat (4) begin
         @(negedge clk);
         chk(out_valid === 1'b0, "t7_stray_dropped", 64'(out_valid), 64'h0);
      end

      // Randomized commands
      for (int k = 0; k < 12; k++) begin
         ar_mode = int'($urandom_range(0, 1));
         orm     = int'($urandom_range(0, 1));
         hold_out_cnt = int'($urandom_range(0, 30));
         ra = {$urandom(), $urandom()};
         ra[2:0] = 3'b000;
         clear_log();
         run_cmd(ra, $urandom_range(1, 50), 1);
         chk(done_cnt == 1, "rand_done_pulses", 64'(done_cnt), 64'd1);
      end

      // Reset while draining
      ar_mode = 0; orm = 1; clear_log();
      hold_out_cnt = 1000;
      run_cmd(64'h4000, 16, 0);
      repeat (30) @(negedge clk);
      chk(busy === 1'b1, "t9_busy_before_reset", 64'(busy), 64'h1);
      chk(out_valid === 1'b1, "t9_buffered", 64'(out_valid), 64'h1);
      @(posedge clk);
      #1 reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      hold_out_cnt = 0;
      @(negedge clk);
      check_reset_values("mid_reset");

      // Recovery after reset
      orm = 1; clear_log();
      run_cmd(64'h5008, 9, 1);
      chk(words_seen == 9, "t10_words", 64'(words_seen), 64'd9);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
